// File: rtl/vend_pkg.sv
// Shared types and coin encodings for the vending transaction sequencer.
// Coin codes: 00=1, 01=5, 10=10, 11=invalid.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_COLLECT,
    S_DISPENSE,
    S_CHANGE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] COIN_1   = 2'b00;
  localparam logic [1:0] COIN_5   = 2'b01;
  localparam logic [1:0] COIN_10  = 2'b10;
  localparam logic [1:0] COIN_BAD = 2'b11;

  localparam logic [3:0] VAL_1  = 4'd1;
  localparam logic [3:0] VAL_5  = 4'd5;
  localparam logic [3:0] VAL_10 = 4'd10;

  function automatic logic [3:0] coin_val(input logic [1:0] code);
    logic [3:0] v;
    unique case (code)
      COIN_1:  v = VAL_1;
      COIN_5:  v = VAL_5;
      COIN_10: v = VAL_10;
      default: v = 4'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Greedy change payout: loads a remainder, emits one coin per enabled
// cycle (10, then 5, then 1) and reports finished once it reaches zero.
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         change_valid,
  output logic [1:0]   change_denom,
  output logic         finished
);

  logic [W-1:0] r_rem;
  logic [1:0]   w_denom;
  logic [3:0]   w_val;

  always_comb begin
    w_denom = COIN_1;
    w_val   = VAL_1;
    if (r_rem >= W'(VAL_10)) begin
      w_denom = COIN_10;
      w_val   = VAL_10;
    end else if (r_rem >= W'(VAL_5)) begin
      w_denom = COIN_5;
      w_val   = VAL_5;
    end
  end

  assign change_valid = en && (r_rem != '0);
  assign change_denom = change_valid ? w_denom : 2'b00;
  assign finished     = (r_rem == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem <= '0;
    end else if (load) begin
      r_rem <= load_val;
    end else if (change_valid) begin
      r_rem <= r_rem - W'(w_val);
    end
  end

endmodule

// File: rtl/vend_txn_sequencer.sv
// Purchase sequencer: multiply, collect coins, dispense, pay change.
// Define VEND_TIMEOUT_EN to refund automatically after COLLECT inactivity.
module vend_txn_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE_W         = 8,
  parameter int QTY_W           = 4,
  parameter int DISPENSE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PRICE_W-1:0] unit_price,
  input  logic [QTY_W-1:0]   quantity,
  input  logic               coin_valid,
  input  logic [1:0]         coin_value,
  input  logic               cancel,
  output logic               busy,
  output logic [PRICE_W-1:0] total_price,
  output logic [PRICE_W-1:0] credit,
  output logic               coin_ack,
  output logic               dispense,
  output logic               change_valid,
  output logic [1:0]         change_denom,
  output logic               done,
  output logic               error
);

  localparam int ACC_W   = PRICE_W + QTY_W;
  localparam int CNT_MAX = (DISPENSE_CYCLES > QTY_W) ? DISPENSE_CYCLES : QTY_W;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(QTY_W - 1);
  localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISPENSE_CYCLES - 1);

  state_t             r_state, w_next;
  logic [ACC_W-1:0]   r_acc, r_mcand, w_acc_next;
  logic [QTY_W-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [PRICE_W-1:0] r_total, r_credit, w_load_val;
  logic [PRICE_W:0]   w_sum;
  logic r_ack, r_refund;
  logic w_load, w_accept, w_cancel, w_coin_ok;
  logic w_timeout, w_to_err, w_finished, w_chg_en;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_sum      = {1'b0, r_credit} + (PRICE_W+1)'(coin_val(coin_value));
  assign w_coin_ok  = coin_valid && (coin_value != COIN_BAD) && !w_sum[PRICE_W];
  assign w_chg_en   = (r_state == S_CHANGE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = r_credit - r_total;
    w_accept   = 1'b0;
    w_cancel   = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (start) w_next = (quantity == '0) ? S_ERR : S_MUL;
      S_MUL:
        if (r_cnt == MUL_LAST)
          w_next = (|w_acc_next[ACC_W-1:PRICE_W]) ? S_ERR : S_COLLECT;
      S_COLLECT: begin
        w_cancel = cancel || w_timeout;
        w_accept = w_coin_ok && !w_cancel;
        if (w_cancel) begin
          w_next     = S_CHANGE;
          w_load     = 1'b1;
          w_load_val = r_credit;
        end else if (r_credit >= r_total) begin
          w_next = S_DISPENSE;
        end
      end
      S_DISPENSE:
        if (r_cnt == DISP_LAST) begin
          w_next = S_CHANGE;
          w_load = 1'b1;
        end
      S_CHANGE:
        if (w_finished) w_next = r_refund ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_total  <= '0;
      r_credit <= '0;
      r_ack    <= 1'b0;
      r_refund <= 1'b0;
    end else begin
      r_ack <= w_accept;
      unique case (r_state)
        S_IDLE:
          if (start) begin
            r_acc    <= '0;
            r_mcand  <= ACC_W'(unit_price);
            r_mplier <= quantity;
            r_cnt    <= '0;
            r_refund <= 1'b0;
            if (quantity != '0) begin
              r_credit <= '0;
              r_total  <= '0;
            end
          end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_next == S_COLLECT) r_total <= w_acc_next[PRICE_W-1:0];
        end
        S_COLLECT: begin
          r_cnt <= '0;
          if (w_accept) r_credit <= w_sum[PRICE_W-1:0];
          if (w_cancel) r_refund <= 1'b1;
        end
        S_DISPENSE: r_cnt <= r_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] r_to;
  logic            r_to_err;

  assign w_timeout = (r_state == S_COLLECT) &&
                     (r_to == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_to_err  = r_to_err;

  // Idle count restarts on COLLECT entry and on every accepted coin.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to     <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to_err <= w_timeout;
      if (r_state != S_COLLECT || w_accept) r_to <= '0;
      else                                  r_to <= r_to + TO_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_to_err  = 1'b0;
`endif

  vend_change_gen #(.W(PRICE_W)) u_change (
    .clk          (clk),
    .reset        (reset),
    .load         (w_load),
    .load_val     (w_load_val),
    .en           (w_chg_en),
    .change_valid (change_valid),
    .change_denom (change_denom),
    .finished     (w_finished)
  );

  assign busy        = (r_state != S_IDLE);
  assign total_price = r_total;
  assign credit      = r_credit;
  assign coin_ack    = r_ack;
  assign dispense    = (r_state == S_DISPENSE);
  assign done        = (r_state == S_DONE);
  assign error       = (r_state == S_ERR) || w_to_err;

endmodule

// File: tb/tb_vend_txn_sequencer.sv
// Scoreboard bench for vend_txn_sequencer: stimulus queues expected
// events, a negedge monitor pops and compares what the DUT emits.
module tb_vend_txn_sequencer;

  localparam int EV_ACK  = 0;
  localparam int EV_CHG  = 1;
  localparam int EV_DISP = 2;
  localparam int EV_DONE = 3;
  localparam int EV_ERR  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] unit_price = '0;
  logic [3:0] quantity = '0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_value = '0;
  logic       cancel = 1'b0;
  logic       busy, coin_ack, dispense, change_valid, done, error;
  logic [7:0] total_price, credit;
  logic [1:0] change_denom;

  typedef struct {
    int kind;
    int val;
  } evt_t;

  evt_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   run_len = 0;

  vend_txn_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .unit_price   (unit_price),
    .quantity     (quantity),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .cancel       (cancel),
    .busy         (busy),
    .total_price  (total_price),
    .credit       (credit),
    .coin_ack     (coin_ack),
    .dispense     (dispense),
    .change_valid (change_valid),
    .change_denom (change_denom),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int k, input int v);
    exp_q.push_back(evt_t'{kind: k, val: v});
  endtask

  task automatic observe(input int k, input int v);
    evt_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_evt: got kind %0d val %0d expected none", k, v);
    end else begin
      e = exp_q.pop_front();
      chk("evt_kind", k, e.kind);
      chk("evt_val", v, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      run_len = 0;
    end else begin
      if (dispense) begin
        run_len++;
      end else if (run_len != 0) begin
        observe(EV_DISP, run_len);
        run_len = 0;
      end
      if (coin_ack)     observe(EV_ACK, int'(credit));
      if (change_valid) observe(EV_CHG, int'(change_denom));
      if (done)         observe(EV_DONE, 0);
      if (error)        observe(EV_ERR, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input int p, input int q);
    unit_price = 8'(p);
    quantity   = 4'(q);
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic coin(input logic [1:0] c);
    coin_valid = 1'b1;
    coin_value = c;
    tick();
    coin_valid = 1'b0;
    coin_value = 2'b00;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    chk(name, int'(busy), 0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_total"}, int'(total_price), 0);
    chk({name, "_credit"}, int'(credit), 0);
    chk({name, "_ack"}, int'(coin_ack), 0);
    chk({name, "_disp"}, int'(dispense), 0);
    chk({name, "_chg"}, int'(change_valid), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_err"}, int'(error), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();

    // Exact payment: 6 x 3 = 18
    start_txn(6, 3);
    repeat (4) tick();
    chk("exact_total", int'(total_price), 18);
    chk("exact_busy", int'(busy), 1);
    push(EV_ACK, 10); coin(2'b10);
    push(EV_ACK, 15); coin(2'b01);
    push(EV_ACK, 16); coin(2'b00);
    push(EV_ACK, 17); coin(2'b00);
    push(EV_ACK, 18); coin(2'b00);
    push(EV_DISP, 16);
    push(EV_DONE, 0);
    wait_idle("exact_idle");
    chk("exact_credit", int'(credit), 18);

    // Overpayment by 2: change is two 1-coins
    start_txn(6, 3);
    repeat (4) tick();
    push(EV_ACK, 10); coin(2'b10);
    push(EV_ACK, 20); coin(2'b10);
    push(EV_DISP, 16);
    push(EV_CHG, 0);
    push(EV_CHG, 0);
    push(EV_DONE, 0);
    wait_idle("over_idle");
    chk("over_credit", int'(credit), 20);

    // Cancel with a simultaneous coin: coin ignored, refund 10 then 5
    start_txn(6, 3);
    repeat (4) tick();
    push(EV_ACK, 10); coin(2'b10);
    push(EV_ACK, 15); coin(2'b01);
    push(EV_CHG, 2);
    push(EV_CHG, 1);
    cancel     = 1'b1;
    coin_valid = 1'b1;
    coin_value = 2'b01;
    tick();
    cancel     = 1'b0;
    coin_valid = 1'b0;
    coin_value = 2'b00;
    wait_idle("cancel_idle");
    chk("cancel_credit", int'(credit), 15);

    // Zero quantity: error straight away, no multiply
    push(EV_ERR, 0);
    start_txn(6, 0);
    tick();
    chk("qty0_no_mul", int'(busy), 0);

    // Product overflow: 100 x 3 = 300
    push(EV_ERR, 0);
    start_txn(100, 3);
    wait_idle("ovf_idle");
    chk("ovf_total", int'(total_price), 0);

    // Rejections: coin during MUL, bad code, credit overflow
    start_txn(255, 1);
    coin(2'b10);
    repeat (3) tick();
    chk("rej_total", int'(total_price), 255);
    coin(2'b11);
    chk("rej_bad_credit", int'(credit), 0);
    for (int i = 1; i <= 25; i++) begin
      push(EV_ACK, i * 10);
      coin(2'b10);
    end
    chk("rej_250", int'(credit), 250);
    coin(2'b10);
    chk("rej_ovf_credit", int'(credit), 250);
    push(EV_ACK, 255); coin(2'b01);
    push(EV_DISP, 16);
    push(EV_DONE, 0);
    wait_idle("rej_idle");

    // Reset in dispense cycle 5, then a fresh purchase
    start_txn(6, 3);
    repeat (4) tick();
    push(EV_ACK, 10); coin(2'b10);
    push(EV_ACK, 20); coin(2'b10);
    begin
      int k = 0;
      while (!dispense && k < 20) begin
        tick();
        k++;
      end
    end
    chk("rst_disp_seen", int'(dispense), 1);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("rst_mid");
    start_txn(2, 1);
    repeat (4) tick();
    chk("post_rst_total", int'(total_price), 2);
    chk("post_rst_busy", int'(busy), 1);
    push(EV_ACK, 1); coin(2'b00);
    push(EV_ACK, 2); coin(2'b00);
    push(EV_DISP, 16);
    push(EV_DONE, 0);
    wait_idle("post_rst_idle");

    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
